pool2d_stream: RTL and testbench

Streaming 2-D pooling engine with an integrated line buffer. It supersedes the separate window-buffer plus `max_pool_2d` pair in the LeNet pipeline. It accepts raster-ordered multi-channel pixels under a valid/ready handshake and emits one pooled pixel per stride-aligned window. It supports max or average mode, overlapping or non-overlapping strides, and downstream backpressure.

---
 rtl/pool2d_stream.sv | 182 ++++++++++++++++++
 tb/tb_pool2d_stream.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool2d_stream.sv
// Streaming K x K max/average pooling over raster-ordered multi-channel pixels.
// Line buffer + sliding window feed one reduction lane per channel; single output register.
module pool2d_lane #(
   parameter int BITWIDTH = 16,
   parameter int N        = 4,
   parameter int SUM_W    = 18,
   parameter int SHIFT    = 2
) (
   input  logic                         mode,
   input  logic [N-1:0][BITWIDTH-1:0]   samples,
   output logic [BITWIDTH-1:0]          result
);
   logic signed [BITWIDTH-1:0] mx;
   logic signed [SUM_W-1:0]    sum;

   always_comb begin
      mx  = samples[0];
      sum = '0;
      for (int i = 0; i < N; i++) begin
         if ($signed(samples[i]) > mx) mx = samples[i];
         sum = sum + SUM_W'($signed(samples[i]));
      end
      // arithmetic shift floors toward -inf; the mean always fits BITWIDTH
      result = mode ? BITWIDTH'(sum >>> SHIFT) : mx;
   end
endmodule

module pool2d_stream #(
   parameter int BITWIDTH = 16,
   parameter int NFMAPS   = 6,
   parameter int KER_SIZE = 2,
   parameter int STRIDE   = 2,
   parameter int IMG_W    = 28,
   parameter int IMG_H    = 28
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       mode,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [NFMAPS*BITWIDTH-1:0] in_act,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [NFMAPS*BITWIDTH-1:0] out_act,
   output logic                       frame_done
);
   localparam int K     = KER_SIZE;
   localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int PW    = (STRIDE > 1) ? $clog2(STRIDE) : 1;
   localparam int LOGK  = (K > 1) ? $clog2(K) : 0;
   localparam int SUM_W = BITWIDTH + 2 * LOGK;
   localparam int SHIFT = $clog2(K * K);

   typedef logic [NFMAPS-1:0][BITWIDTH-1:0] pix_t;

   if (K < 1 || K > IMG_H) begin : g_bad_k
      $error("pool2d_stream: KER_SIZE must be in 1..IMG_H");
   end
   if (STRIDE < 1 || STRIDE > K) begin : g_bad_s
      $error("pool2d_stream: STRIDE must be in 1..KER_SIZE");
   end
   if ((K & (K - 1)) != 0) begin : g_np2_k
      $warning("pool2d_stream: average mode unsupported, KER_SIZE is not a power of two");
   end

   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [PW-1:0] col_ph, row_ph;
   logic          mode_q;
   logic          accept, col_last, row_last, first_pix, eff_mode, emit;
   pix_t          win [K][K];
   pix_t          pooled;

   assign in_ready  = !out_valid || out_ready;
   assign accept    = in_valid && in_ready && !flush;
   assign col_last  = (col == CW'(IMG_W - 1));
   assign row_last  = (row == RW'(IMG_H - 1));
   assign first_pix = (col == '0) && (row == '0);
   assign eff_mode  = first_pix ? mode : mode_q;
   // phase counters hold (pos-(K-1)) mod STRIDE once pos reaches K-1, else 0
   assign emit      = accept && (32'(col) >= K - 1) && (32'(row) >= K - 1) &&
                      (col_ph == '0) && (row_ph == '0);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         col    <= '0;
         row    <= '0;
         col_ph <= '0;
         row_ph <= '0;
         mode_q <= 1'b0;
      end else if (flush) begin
         col    <= '0;
         row    <= '0;
         col_ph <= '0;
         row_ph <= '0;
      end else if (accept) begin
         if (first_pix) mode_q <= mode;
         if (col_last) begin
            col    <= '0;
            col_ph <= '0;
            if (row_last) begin
               row    <= '0;
               row_ph <= '0;
            end else begin
               row <= row + 1'b1;
               if (32'(row) >= K - 1)
                  row_ph <= (row_ph == PW'(STRIDE - 1)) ? '0 : row_ph + 1'b1;
            end
         end else begin
            col <= col + 1'b1;
            if (32'(col) >= K - 1)
               col_ph <= (col_ph == PW'(STRIDE - 1)) ? '0 : col_ph + 1'b1;
         end
      end
   end

   if (K > 1) begin : g_win
      pix_t lb    [K-1][IMG_W];  // lb[0] = previous row, lb[K-2] = oldest
      pix_t win_q [K][K-1];      // K-1 older columns; newest column comes in live
      pix_t new_col [K];

      always_comb begin
         for (int r = 0; r < K - 1; r++) new_col[r] = lb[K-2-r][col];
         new_col[K-1] = in_act;
      end

      always_ff @(posedge clk) begin
         if (accept) begin
            for (int j = K - 2; j > 0; j--) lb[j][col] <= lb[j-1][col];
            lb[0][col] <= in_act;
            for (int r = 0; r < K; r++) begin
               for (int c = 0; c < K - 2; c++) win_q[r][c] <= win_q[r][c+1];
               win_q[r][K-2] <= new_col[r];
            end
         end
      end

      always_comb begin
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) win[r][c] = win_q[r][c];
            win[r][K-1] = new_col[r];
         end
      end
   end else begin : g_win1
      always_comb win[0][0] = in_act;
   end

   for (genvar ch = 0; ch < NFMAPS; ch++) begin : g_lane
      logic [K*K-1:0][BITWIDTH-1:0] samples;
      for (genvar r = 0; r < K; r++) begin : g_r
         for (genvar c = 0; c < K; c++) begin : g_c
            assign samples[r*K+c] = win[r][c][ch];
         end
      end
      pool2d_lane #(
         .BITWIDTH(BITWIDTH), .N(K*K), .SUM_W(SUM_W), .SHIFT(SHIFT)
      ) u_lane (
         .mode(eff_mode), .samples(samples), .result(pooled[ch])
      );
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_valid  <= 1'b0;
         out_act    <= '0;
         frame_done <= 1'b0;
      end else if (flush) begin
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= accept && col_last && row_last;
         if (emit) begin
            out_valid <= 1'b1;
            out_act   <= pooled;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_pool2d_stream.sv
// Scoreboard bench for pool2d_stream: 4x4/K2/S2 six-channel instance plus a 3x3/K2/S1 instance.
module tb_pool2d_stream;
   localparam int BW = 16;
   localparam int NF = 6;
   typedef logic [NF-1:0][BW-1:0] pix_t;

   logic clk = 1'b0, rstn = 1'b0, mode = 1'b0, flush = 1'b0;
   logic in_valid = 1'b0, out_ready = 1'b1, sel = 1'b0, bp_en = 1'b0;
   logic [NF*BW-1:0] in_act = '0;
   logic in_ready_a, out_valid_a, fd_a, in_ready_b, out_valid_b, fd_b;
   logic [NF*BW-1:0] out_act_a;
   logic [BW-1:0]    out_act_b;
   logic in_ready_m, out_valid_m, fd_m;
   pix_t act_m;

   int tests = 0, fails = 0, fd_cnt = 0, cyc = 0;
   pix_t exp_q[$];
   bit   stall_prev = 0;
   pix_t stall_act;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   pool2d_stream #(.BITWIDTH(BW), .NFMAPS(NF), .KER_SIZE(2), .STRIDE(2), .IMG_W(4), .IMG_H(4)) dut (
      .clk(clk), .rstn(rstn), .mode(mode), .flush(flush), .in_valid(in_valid && !sel),
      .in_ready(in_ready_a), .in_act(in_act), .out_valid(out_valid_a), .out_ready(out_ready),
      .out_act(out_act_a), .frame_done(fd_a));

   pool2d_stream #(.BITWIDTH(BW), .NFMAPS(1), .KER_SIZE(2), .STRIDE(1), .IMG_W(3), .IMG_H(3)) dut_ov (
      .clk(clk), .rstn(rstn), .mode(mode), .flush(flush), .in_valid(in_valid && sel),
      .in_ready(in_ready_b), .in_act(in_act[BW-1:0]), .out_valid(out_valid_b), .out_ready(out_ready),
      .out_act(out_act_b), .frame_done(fd_b));

   assign in_ready_m  = sel ? in_ready_b : in_ready_a;
   assign out_valid_m = sel ? out_valid_b : out_valid_a;
   assign fd_m        = sel ? fd_b : fd_a;
   assign act_m       = sel ? pix_t'({{((NF-1)*BW){1'b0}}, out_act_b}) : pix_t'(out_act_a);

   // random downstream stall generator
   always @(posedge clk) begin
      #2;
      if (bp_en) out_ready = 1'($urandom_range(0, 1));
   end

   // output monitor: scoreboard pop, hold stability, frame_done alignment
   always @(negedge clk) begin
      pix_t e;
      if (rstn) begin
         if (stall_prev) begin
            tests++;
            if (out_valid_m !== 1'b1 || act_m !== stall_act) begin
               fails++;
               $display("FAIL hold: valid=%b act=%h required valid=1 act=%h", out_valid_m, act_m, stall_act);
            end
         end
         if (fd_m === 1'b1) begin
            fd_cnt++;
            tests++;
            if (out_valid_m !== 1'b1) begin
               fails++;
               $display("FAIL frame_done_valid: out_valid=%b required 1", out_valid_m);
            end
         end
         if (out_valid_m === 1'b1 && out_ready === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL extra_beat: got %h with empty scoreboard", act_m);
            end else begin
               e = exp_q.pop_front();
               if (act_m !== e) begin
                  fails++;
                  $display("FAIL beat: got %h required %h", act_m, e);
               end
            end
         end
         stall_prev = out_valid_m && !out_ready && !flush;
         stall_act  = act_m;
      end else begin
         stall_prev = 0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic push4(input int a0, input int a1, input int a2, input int a3, input bit single);
      int   v[4];
      pix_t p;
      v = '{a0, a1, a2, a3};
      for (int k = 0; k < 4; k++) begin
         for (int c = 0; c < NF; c++) p[c] = (single && c > 0) ? '0 : BW'(v[k] + 100 * c);
         exp_q.push_back(p);
      end
   endtask

   task automatic send(input int v, input bit m);
      bit acc = 0;
      int budget = 0;
      mode = m;
      in_valid = 1'b1;
      for (int c = 0; c < NF; c++) in_act[c*BW +: BW] = BW'(v + 100 * c);
      while (!acc && budget < 200) begin
         @(negedge clk);
         if (in_ready_m) acc = 1;
         else budget++;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!acc) begin
         tests++;
         fails++;
         $display("FAIL accept_timeout: in_ready stayed 0 for pixel %0d", v);
      end
   endtask

   task automatic run_frame(input int sgn, input bit m, input bit toggle, input int npix);
      for (int i = 0; i < npix; i++) send(sgn * i, (toggle && i >= npix / 2) ? !m : m);
   endtask

   task automatic drain();
      int n = 0;
      bp_en = 1'b0;
      out_ready = 1'b1;
      while (exp_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      tests += 4;
      if (out_valid_m !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b required 0", out_valid_m); end
      if (act_m !== '0)         begin fails++; $display("FAIL reset_out_act: got %h required 0", act_m); end
      if (fd_m !== 1'b0)        begin fails++; $display("FAIL reset_frame_done: got %b required 0", fd_m); end
      if (in_ready_m !== 1'b1)  begin fails++; $display("FAIL reset_in_ready: got %b required 1", in_ready_m); end
      rstn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_max();
      int fd0 = fd_cnt;
      push4(5, 7, 13, 15, 0);
      run_frame(1, 0, 0, 16);
      drain();
      tests += 2;
      if (exp_q.size() != 0) begin fails++; $display("FAIL max_missing: %0d beats outstanding, required 0", exp_q.size()); end
      if (fd_cnt - fd0 != 1) begin fails++; $display("FAIL max_frame_done: got %0d pulses required 1", fd_cnt - fd0); end
      exp_q.delete();
   endtask

   task automatic test_avg();
      int fd0 = fd_cnt;
      push4(2, 4, 10, 12, 0);
      run_frame(1, 1, 0, 16);
      push4(-3, -5, -11, -13, 0);
      run_frame(-1, 1, 0, 16);
      drain();
      tests += 2;
      if (exp_q.size() != 0) begin fails++; $display("FAIL avg_missing: %0d beats outstanding, required 0", exp_q.size()); end
      if (fd_cnt - fd0 != 2) begin fails++; $display("FAIL avg_frame_done: got %0d pulses required 2", fd_cnt - fd0); end
      exp_q.delete();
   endtask

   task automatic test_overlap();
      int fd0 = fd_cnt;
      sel = 1'b1;
      push4(4, 5, 7, 8, 1);
      run_frame(1, 0, 0, 9);
      drain();
      tests += 2;
      if (exp_q.size() != 0) begin fails++; $display("FAIL overlap_missing: %0d beats outstanding, required 0", exp_q.size()); end
      if (fd_cnt - fd0 != 1) begin fails++; $display("FAIL overlap_frame_done: got %0d pulses required 1", fd_cnt - fd0); end
      exp_q.delete();
      sel = 1'b0;
   endtask

   task automatic test_backpressure();
      int fd0 = fd_cnt;
      push4(5, 7, 13, 15, 0);
      push4(5, 7, 13, 15, 0);
      bp_en = 1'b1;
      for (int i = 0; i < 6; i++) send(i, 0);
      bp_en = 1'b0;
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         tests++;
         if (in_ready_m !== 1'b0 || out_valid_m !== 1'b1) begin
            fails++;
            $display("FAIL bp_stall: in_ready=%b out_valid=%b required 0/1", in_ready_m, out_valid_m);
         end
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      bp_en = 1'b1;
      for (int i = 6; i < 16; i++) send(i, 0);
      run_frame(1, 0, 0, 16);
      drain();
      tests += 2;
      if (exp_q.size() != 0) begin fails++; $display("FAIL bp_missing: %0d beats outstanding, required 0", exp_q.size()); end
      if (fd_cnt - fd0 != 2) begin fails++; $display("FAIL bp_frame_done: got %0d pulses required 2", fd_cnt - fd0); end
      exp_q.delete();
   endtask

   task automatic test_flush();
      int fd0 = fd_cnt;
      bp_en = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) send(i, 0);
      flush = 1'b1;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      tests += 2;
      if (out_valid_m !== 1'b0) begin fails++; $display("FAIL flush_out_valid: got %b required 0", out_valid_m); end
      if (fd_m !== 1'b0)        begin fails++; $display("FAIL flush_frame_done: got %b required 0", fd_m); end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      push4(5, 7, 13, 15, 0);
      run_frame(1, 0, 0, 16);
      drain();
      tests += 2;
      if (exp_q.size() != 0) begin fails++; $display("FAIL flush_missing: %0d beats outstanding, required 0", exp_q.size()); end
      if (fd_cnt - fd0 != 1) begin fails++; $display("FAIL flush_frame_done_cnt: got %0d pulses required 1", fd_cnt - fd0); end
      exp_q.delete();
   endtask

   task automatic test_reset_mid();
      int fd0 = fd_cnt;
      bp_en = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) send(i, 1);
      #1 rstn = 1'b0;
      #1;
      tests += 4;
      if (out_valid_m !== 1'b0) begin fails++; $display("FAIL rst_mid_out_valid: got %b required 0", out_valid_m); end
      if (act_m !== '0)         begin fails++; $display("FAIL rst_mid_out_act: got %h required 0", act_m); end
      if (fd_m !== 1'b0)        begin fails++; $display("FAIL rst_mid_frame_done: got %b required 0", fd_m); end
      if (in_ready_m !== 1'b1)  begin fails++; $display("FAIL rst_mid_in_ready: got %b required 1", in_ready_m); end
      @(negedge clk);
      rstn = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      push4(5, 7, 13, 15, 0);
      run_frame(1, 0, 0, 16);
      drain();
      tests += 2;
      if (exp_q.size() != 0) begin fails++; $display("FAIL rst_mid_missing: %0d beats outstanding, required 0", exp_q.size()); end
      if (fd_cnt - fd0 != 1) begin fails++; $display("FAIL rst_mid_frame_done_cnt: got %0d pulses required 1", fd_cnt - fd0); end
      exp_q.delete();
   endtask

   task automatic test_back_to_back();
      int fd0 = fd_cnt;
      int c0;
      out_ready = 1'b1;
      push4(5, 7, 13, 15, 0);
      push4(2, 4, 10, 12, 0);
      c0 = cyc;
      run_frame(1, 0, 0, 16);
      run_frame(1, 1, 1, 16);
      tests++;
      if (cyc - c0 != 32) begin fails++; $display("FAIL b2b_throughput: got %0d cycles required 32", cyc - c0); end
      drain();
      tests += 2;
      if (exp_q.size() != 0) begin fails++; $display("FAIL b2b_missing: %0d beats outstanding, required 0", exp_q.size()); end
      if (fd_cnt - fd0 != 2) begin fails++; $display("FAIL b2b_frame_done: got %0d pulses required 2", fd_cnt - fd0); end
      exp_q.delete();
   endtask

   initial begin
      test_reset();
      test_max();
      test_avg();
      test_overlap();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
